cpu_ienc: RTL and testbench

Instruction encoder: the inverse of the pipeline's instruction decoder. It accepts field-level instruction requests (kind, funct3, register indices, full 32-bit immediate) and emits RV32I/M instruction words on a valid/ready stream. The debug/program-load path uses it to inject instruction words into the fetch side. It range-checks immediates and expands two pseudo-instructions (LI, CALL) into two-word sequences.

---
 rtl/cpu_ienc_pkg.sv | 71 +++++++
 rtl/cpu_ienc_fmt.sv | 101 ++++++++++
 rtl/cpu_ienc.sv | 140 ++++++++++++++
 tb/tb_cpu_ienc.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ienc_pkg.sv
// Shared constants for the instruction encoder: request kinds, RV32I/M
// opcode/funct fields, FSM state codes and small encoding helpers.
// Optional feature macro used by the encoder: CPU_IENC_M_EXT_EN.
package cpu_ienc_pkg;

    typedef enum logic [3:0] {
        KIND_OP     = 4'd0,
        KIND_OP_IMM = 4'd1,
        KIND_LUI    = 4'd2,
        KIND_AUIPC  = 4'd3,
        KIND_JAL    = 4'd4,
        KIND_JALR   = 4'd5,
        KIND_BRANCH = 4'd6,
        KIND_LOAD   = 4'd7,
        KIND_STORE  = 4'd8,
        KIND_LI     = 4'd9,
        KIND_CALL   = 4'd10,
        KIND_NOP    = 4'd11
    } kind_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [1:0] ALT_BASE   = 2'd0;
    localparam logic [1:0] ALT_ALT    = 2'd1;
    localparam logic [1:0] ALT_MULDIV = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Canonical NOP is ADDI x0, x0, 0.
    localparam logic [31:0] NOP_WORD = {12'd0, REG_X0, F3_ADD, REG_X0, OPC_OP_IMM};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FIRST = 2'd1;
    localparam logic [1:0] ST_LAST  = 2'd2;

    typedef struct packed {
        logic [19:0] hi;
        logic [11:0] lo;
    } split_t;

    // True when v is representable as a signed value of the given bit width.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] mask;
        mask = ~32'd0 << (bits - 1);
        return ((v & mask) == 32'd0) || ((v & mask) == mask);
    endfunction

    // Upper part is rounded so that hi<<12 plus sign-extended lo equals v.
    function automatic split_t li_split(input logic [31:0] v);
        logic [31:0] rounded;
        rounded = v + 32'h0000_0800;
        return '{hi: rounded[31:12], lo: v[11:0]};
    endfunction

endpackage

// File: rtl/cpu_ienc_fmt.sv
// Combinational single-word formatter: one base-kind request to one
// RV32I/M word plus an illegal flag for range or funct7 violations.
// Optional feature macro: CPU_IENC_M_EXT_EN (enables funct7 0000001 on OP).
module cpu_ienc_fmt
    import cpu_ienc_pkg::*;
(
    input  kind_e       kind,
    input  logic [2:0]  funct3,
    input  logic [1:0]  alt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic [6:0] funct7;
    logic       alt_ok;
    logic       is_shift;

    // Map the alt selector to funct7 and decide whether it is legal here.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        funct7   = F7_BASE;
        alt_ok   = 1'b0;
        is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);
        case (alt)
            ALT_BASE: begin
                funct7 = F7_BASE;
                alt_ok = 1'b1;
            end
            ALT_ALT: begin
                funct7 = F7_ALT;
                alt_ok = ((kind == KIND_OP) && ((funct3 == F3_ADD) || (funct3 == F3_SR)))
                      || ((kind == KIND_OP_IMM) && (funct3 == F3_SR));
            end
            ALT_MULDIV: begin
                funct7 = F7_MULDIV;
`ifdef CPU_IENC_M_EXT_EN
                alt_ok = (kind == KIND_OP);
`else
                alt_ok = 1'b0;
`endif
            end
            default: alt_ok = 1'b0;
        endcase
    end

    // Assemble the word for the requested format and range-check the immediate.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            KIND_OP: word = {funct7, rs2, rs1, funct3, rd, OPC_OP};
            KIND_OP_IMM: begin
                if (is_shift) begin
                    illegal = (imm[31:5] != 27'd0);
                    word    = {funct7, imm[4:0], rs1, funct3, rd, OPC_OP_IMM};
                end else begin
                    illegal = !fits_signed(imm, 12);
                    word    = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
                end
            end
            KIND_LUI: begin
                illegal = (imm[11:0] != 12'd0);
                word    = {imm[31:12], rd, OPC_LUI};
            end
            KIND_AUIPC: begin
                illegal = (imm[11:0] != 12'd0);
                word    = {imm[31:12], rd, OPC_AUIPC};
            end
            KIND_JAL: begin
                illegal = !fits_signed(imm, 21) || imm[0];
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            end
            KIND_JALR: begin
                illegal = !fits_signed(imm, 12);
                word    = {imm[11:0], rs1, F3_ADD, rd, OPC_JALR};
            end
            KIND_BRANCH: begin
                illegal = !fits_signed(imm, 13) || imm[0];
                word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            end
            KIND_LOAD: begin
                illegal = !fits_signed(imm, 12);
                word    = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            end
            KIND_STORE: begin
                illegal = !fits_signed(imm, 12);
                word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            end
            KIND_NOP: word = NOP_WORD;
            default:  illegal = 1'b1;
        endcase
        if (!alt_ok) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_ienc.sv
// Instruction encoder top: expands LI/CALL pseudo-instructions into up to
// two base requests, formats them, and streams the words on valid/ready.
// Optional feature macro: CPU_IENC_M_EXT_EN (see cpu_ienc_fmt).
module cpu_ienc
    import cpu_ienc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_alt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        err
);

    logic [1:0]  state;
    logic [31:0] word1_q;
    split_t      split;
    kind_e       kind0, kind1;
    logic [2:0]  f3_0;
    logic [1:0]  alt0;
    logic [4:0]  rs1_0;
    logic [31:0] imm0, imm1;
    logic        two_word, pseudo_bad;
    logic [31:0] word0, word1;
    logic        ill0, ill1, illegal, accept;

    // Rewrite pseudo-instructions into one or two base-kind requests.
    always_comb begin
        split      = li_split(in_imm);
        kind0      = kind_e'(in_kind);
        f3_0       = in_funct3;
        alt0       = in_alt;
        rs1_0      = in_rs1;
        imm0       = in_imm;
        kind1      = KIND_OP_IMM;
        imm1       = {{20{split.lo[11]}}, split.lo};
        two_word   = 1'b0;
        pseudo_bad = 1'b0;
        if (kind_e'(in_kind) == KIND_LI) begin
            pseudo_bad = (in_alt != ALT_BASE);
            alt0       = ALT_BASE;
            f3_0       = F3_ADD;
            if (split.hi == 20'd0) begin
                kind0 = KIND_OP_IMM;
                rs1_0 = REG_X0;
                imm0  = imm1;
            end else begin
                kind0    = KIND_LUI;
                imm0     = {split.hi, 12'd0};
                two_word = (split.lo != 12'd0);
            end
        end else if (kind_e'(in_kind) == KIND_CALL) begin
            pseudo_bad = (in_alt != ALT_BASE);
            alt0       = ALT_BASE;
            kind0      = KIND_AUIPC;
            imm0       = {split.hi, 12'd0};
            kind1      = KIND_JALR;
            two_word   = 1'b1;
        end
    end

    cpu_ienc_fmt u_fmt0 (
        .kind    (kind0),
        .funct3  (f3_0),
        .alt     (alt0),
        .rd      (in_rd),
        .rs1     (rs1_0),
        .rs2     (in_rs2),
        .imm     (imm0),
        .word    (word0),
        .illegal (ill0)
    );

    cpu_ienc_fmt u_fmt1 (
        .kind    (kind1),
        .funct3  (F3_ADD),
        .alt     (ALT_BASE),
        .rd      (in_rd),
        .rs1     (in_rd),
        .rs2     (in_rs2),
        .imm     (imm1),
        .word    (word1),
        .illegal (ill1)
    );

    // Handshake derived from the held-word state; flush blocks new requests.
    always_comb begin
        illegal   = ill0 || (two_word && ill1) || pseudo_bad;
        in_ready  = !flush && ((state == ST_IDLE) || ((state == ST_LAST) && out_ready));
        accept    = in_valid && in_ready;
        out_valid = (state != ST_IDLE);
        out_last  = (state == ST_LAST);
    end

    // Word-holding FSM: load on accept, advance to word1, drain on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_instr <= '0;
            word1_q   <= '0;
            err       <= 1'b0;
        end else if (flush) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state <= ST_IDLE;
            err   <= 1'b0;
        end else begin
            err <= accept && illegal;
            if (accept) begin
                if (illegal) begin
                    state <= ST_IDLE;
                end else begin
                    state     <= two_word ? ST_FIRST : ST_LAST;
                    out_instr <= word0;
                    word1_q   <= word1;
                end
            end else if (out_ready) begin
                case (state)
                    ST_FIRST: begin
                        state     <= ST_LAST;
                        out_instr <= word1_q;
                    end
                    ST_LAST: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_ienc.sv
// Directed self-checking bench for cpu_ienc with hand-computed words.
// Expectations for the mul/div case follow the CPU_IENC_M_EXT_EN macro.
module tb_cpu_ienc;
    import cpu_ienc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_kind = '0;
    logic [2:0]  in_funct3 = '0;
    logic [1:0]  in_alt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_last;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_ienc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_funct3 (in_funct3),
        .in_alt    (in_alt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request, wait (bounded) for in_ready, and return 1 time unit after the accept edge.
    task automatic issue(input kind_e k, input logic [2:0] f3, input logic [1:0] a,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        int n;
        n = 0;
        @(negedge clk);
        in_kind = k; in_funct3 = f3; in_alt = a;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w, input logic last);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_instr"}, out_instr, w);
        check({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic expect_err(input string tag);
        check({tag, "_err"}, {31'd0, err}, 32'd1);
        check({tag, "_novalid"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_err_clear"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADDI x1, x0, 5
        issue(KIND_OP_IMM, 3'b000, 2'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        expect_word("addi", 32'h0050_0093, 1'b1);

        // LI x5, 0x12345FFF -> LUI + ADDI
        issue(KIND_LI, 3'b000, 2'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        expect_word("li_w0", 32'h1234_62B7, 1'b0);
        check("li_w0_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        expect_word("li_w1", 32'hFFF2_8293, 1'b1);

        // LI x7, 7 -> single ADDI
        issue(KIND_LI, 3'b000, 2'd0, 5'd7, 5'd0, 5'd0, 32'd7);
        expect_word("li_small", 32'h0070_0393, 1'b1);

        // JAL x1, 2048 and odd offset
        issue(KIND_JAL, 3'b000, 2'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        expect_word("jal", 32'h0010_00EF, 1'b1);
        issue(KIND_JAL, 3'b000, 2'd0, 5'd1, 5'd0, 5'd0, 32'd3);
        expect_err("jal_odd");

        // BEQ x1, x2, -4
        issue(KIND_BRANCH, 3'b000, 2'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        expect_word("beq", 32'hFE20_8EE3, 1'b1);

        // Range boundaries
        issue(KIND_OP_IMM, 3'b000, 2'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        expect_err("addi_2048");
        issue(KIND_OP_IMM, 3'b001, 2'd0, 5'd1, 5'd1, 5'd0, 32'd32);
        expect_err("slli_32");
        issue(KIND_LUI, 3'b000, 2'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1001);
        expect_err("lui_low");

        // SUB x3, x1, x2
        issue(KIND_OP, 3'b000, 2'd1, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_word("sub", 32'h4020_81B3, 1'b1);

        // MUL x3, x1, x2
        issue(KIND_OP, 3'b000, 2'd2, 5'd3, 5'd1, 5'd2, 32'd0);
`ifdef CPU_IENC_M_EXT_EN
        expect_word("mul", 32'h0220_81B3, 1'b1);
`else
        expect_err("mul");
`endif

        // Backpressure on a two-word LI
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        issue(KIND_LI, 3'b000, 2'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        expect_word("stall_w0", 32'h1234_62B7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            expect_word("stall_hold", 32'h1234_62B7, 1'b0);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        expect_word("stall_w1", 32'hFFF2_8293, 1'b1);
        @(posedge clk);

        // Flush during CALL x1, 0x1000 with a competing request
        @(negedge clk);
        out_ready = 1'b0;
        issue(KIND_CALL, 3'b000, 2'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1000);
        expect_word("call_w0", 32'h0000_1097, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        in_kind = KIND_NOP;
        in_valid = 1'b1;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_err", {31'd0, err}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("flush_no_word1", {31'd0, out_valid}, 32'd0);
        end

        // Post-flush request encodes normally
        issue(KIND_NOP, 3'b000, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        expect_word("nop", 32'h0000_0013, 1'b1);
        // Back-to-back single words at full rate
        issue(KIND_OP_IMM, 3'b000, 2'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        expect_word("b2b", 32'h0050_0093, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
